// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: serialises a leader, 32 data bits (LSB first)
// and a stop burst, or a short repeat frame, and drives the IR LED with a
// carrier during marks. Every output is registered from next-state values,
// so busy and the envelope rise in the cycle after a request is accepted.
module ir_nec_tx #(
  parameter int UNIT_CYC     = 28125,
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 439
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic       tx_repeat,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_cmd,
  output logic       IRDA_TXD,
  output logic       ir_env,
  output logic       busy,
  output logic       tx_done
);

  localparam int UW = $clog2(UNIT_CYC);
  localparam int CW = $clog2(CARRIER_DIV);
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYC - 1);
  localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] CAR_HIGH  = CW'(CARRIER_HIGH);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_BIT_MARK   = 3'd3,
    S_BIT_SPACE  = 3'd4,
    S_STOP_MARK  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [UW-1:0] unit_q, unit_d;    // cycles within the current unit
  logic [4:0]    seg_q, seg_d;      // units within the current state
  logic [5:0]    bit_q, bit_d;      // data bits already sent
  logic [31:0]   shift_q, shift_d;  // bit 0 is the bit on air
  logic          rep_q, rep_d;      // current frame is a repeat frame
  logic [CW-1:0] car_q, car_d;      // carrier phase within one period
  logic          env_d, txd_d, busy_d, done_d;
  logic          accept_s, unit_end_s, seg_end_s;

  // Number of units spent in a state, minus one.
  function automatic logic [4:0] seg_last(input state_t s, input logic rep, input logic bit_v);
    case (s)
      S_LEAD_MARK:  seg_last = 5'd15;
      S_LEAD_SPACE: seg_last = rep ? 5'd3 : 5'd7;
      S_BIT_SPACE:  seg_last = bit_v ? 5'd2 : 5'd0;
      default:      seg_last = 5'd0;
    endcase
  endfunction

  // States during which the LED envelope is on.
  function automatic logic is_mark(input state_t s);
    case (s)
      S_LEAD_MARK, S_BIT_MARK, S_STOP_MARK: is_mark = 1'b1;
      default:                              is_mark = 1'b0;
    endcase
  endfunction

  // Next-state, timing counters, carrier phase and next output values.
  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    seg_d   = seg_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rep_d   = rep_q;
    car_d   = '0;
    // A request in the tx_done cycle is dropped, not deferred.
    accept_s   = (state_q == S_IDLE) && !tx_done && (tx_start || tx_repeat);
    unit_end_s = (unit_q == UNIT_LAST);
    seg_end_s  = (seg_q == seg_last(state_q, rep_q, shift_q[0]));

    if (state_q == S_IDLE) begin
      unit_d = '0;
      seg_d  = 5'd0;
      bit_d  = 6'd0;
      if (accept_s) begin
        state_d = S_LEAD_MARK;
        if (tx_start) begin
          shift_d = {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
          rep_d   = 1'b0;
        end else begin
          shift_d = 32'd0;
          rep_d   = 1'b1;
        end
      end else begin
        state_d = S_IDLE;
      end
    end else if (unit_end_s) begin
      unit_d = '0;
      if (seg_end_s) begin
        seg_d = 5'd0;
        case (state_q)
          S_LEAD_MARK:  state_d = S_LEAD_SPACE;
          S_LEAD_SPACE: state_d = rep_q ? S_STOP_MARK : S_BIT_MARK;
          S_BIT_MARK:   state_d = S_BIT_SPACE;
          S_BIT_SPACE: begin
            shift_d = {1'b0, shift_q[31:1]};
            bit_d   = bit_q + 6'd1;
            state_d = (bit_q == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
          end
          S_STOP_MARK: begin
            state_d = S_IDLE;
            bit_d   = 6'd0;
            shift_d = 32'd0;
            rep_d   = 1'b0;
          end
          default:      state_d = S_IDLE;
        endcase
      end else begin
        seg_d = seg_q + 5'd1;
      end
    end else begin
      unit_d = unit_q + 1'b1;
    end

    // Every mark is entered from a space or IDLE, so restarting the phase
    // on entry makes each mark begin with the carrier high.
    if (is_mark(state_d)) begin
      if (!is_mark(state_q)) begin
        car_d = '0;
      end else if (car_q == CAR_LAST) begin
        car_d = '0;
      end else begin
        car_d = car_q + 1'b1;
      end
    end else begin
      car_d = '0;
    end

    env_d  = is_mark(state_d);
    txd_d  = is_mark(state_d) && (car_d < CAR_HIGH);
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP_MARK) && (state_d == S_IDLE);
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      unit_q   <= '0;
      seg_q    <= 5'd0;
      bit_q    <= 6'd0;
      shift_q  <= 32'd0;
      rep_q    <= 1'b0;
      car_q    <= '0;
      ir_env   <= 1'b0;
      IRDA_TXD <= 1'b0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state_q  <= state_d;
      unit_q   <= unit_d;
      seg_q    <= seg_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      rep_q    <= rep_d;
      car_q    <= car_d;
      ir_env   <= env_d;
      IRDA_TXD <= txd_d;
      busy     <= busy_d;
      tx_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx: builds the expected envelope/carrier waveform of each
// frame from NEC segment lengths and checks the captured waveform against it.
module tb_ir_nec_tx;

  localparam int UNIT = 10;
  localparam int DIV  = 4;
  localparam int HIGH = 1;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_start = 1'b0;
  logic       tx_repeat = 1'b0;
  logic [7:0] tx_addr = 8'h00;
  logic [7:0] tx_cmd = 8'h00;
  logic       IRDA_TXD, ir_env, busy, tx_done;

  int n_checks = 0;
  int n_fail = 0;
  bit exp_env[$];
  bit exp_txd[$];
  bit obs_env[$];
  bit obs_txd[$];
  int runs[$];
  int busy_len;
  int done_in_busy;

  always #5 CLOCK_50 = ~CLOCK_50;

  ir_nec_tx #(.UNIT_CYC(UNIT), .CARRIER_DIV(DIV), .CARRIER_HIGH(HIGH)) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .tx_start(tx_start), .tx_repeat(tx_repeat),
    .tx_addr(tx_addr), .tx_cmd(tx_cmd), .IRDA_TXD(IRDA_TXD), .ir_env(ir_env),
    .busy(busy), .tx_done(tx_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One segment of the reference waveform; carrier phase restarts per mark.
  task automatic add_seg(input bit lvl, input int units);
    for (int k = 0; k < units * UNIT; k++) begin
      exp_env.push_back(lvl);
      exp_txd.push_back(lvl && ((k % DIV) < HIGH));
    end
  endtask

  task automatic build_model(input bit rep, input logic [7:0] a, input logic [7:0] c);
    logic [31:0] w;
    exp_env.delete();
    exp_txd.delete();
    add_seg(1'b1, 16);
    if (rep) begin
      add_seg(1'b0, 4);
    end else begin
      add_seg(1'b0, 8);
      w = {~c, c, ~a, a};
      for (int b = 0; b < 32; b++) begin
        add_seg(1'b1, 1);
        add_seg(1'b0, w[b] ? 3 : 1);
      end
    end
    add_seg(1'b1, 1);
  endtask

  // Issue a request for one cycle (called at a falling edge), then scramble inputs.
  task automatic request(input bit s, input bit r, input logic [7:0] a, input logic [7:0] c);
    tx_start = s;
    tx_repeat = r;
    tx_addr = a;
    tx_cmd = c;
    @(negedge CLOCK_50);
    tx_start = 1'b0;
    tx_repeat = 1'b0;
    tx_addr = 8'($urandom);
    tx_cmd = 8'($urandom);
  endtask

  // Record the waveform while busy; optionally poke tx_start while busy and in the done cycle.
  task automatic capture(input int inject_at, input logic [7:0] inj_addr, input bit inject_done);
    obs_env.delete();
    obs_txd.delete();
    busy_len = 0;
    done_in_busy = 0;
    while (busy === 1'b1 && busy_len < 4000) begin
      obs_env.push_back(ir_env);
      obs_txd.push_back(IRDA_TXD);
      if (tx_done !== 1'b0) done_in_busy++;
      busy_len++;
      if (busy_len == inject_at) begin
        tx_start = 1'b1;
        tx_addr = inj_addr;
      end else begin
        tx_start = 1'b0;
      end
      @(negedge CLOCK_50);
    end
    tx_start = 1'b0;
    check("busy_bound", 32'(busy_len < 4000), 32'd1);
    check("done_pulse", 32'(tx_done), 32'd1);
    if (inject_done) begin
      tx_start = 1'b1;
      tx_addr = inj_addr;
    end
    @(negedge CLOCK_50);
    tx_start = 1'b0;
    check("done_single", 32'(tx_done), 32'd0);
    check("idle_after", 32'(busy), 32'd0);
  endtask

  // Compare captured waveform with the model and decode it like a receiver would.
  task automatic compare_frame(input string name, input bit rep, input logic [7:0] a, input logic [7:0] c);
    int env_err = 0;
    int txd_err = 0;
    int n;
    logic [31:0] word = 32'd0;
    build_model(rep, a, c);
    check({name, "_busy_len"}, 32'(busy_len), 32'(exp_env.size()));
    n = (obs_env.size() < exp_env.size()) ? obs_env.size() : exp_env.size();
    for (int i = 0; i < n; i++) begin
      if (obs_env[i] != exp_env[i]) env_err++;
      if (obs_txd[i] != exp_txd[i]) txd_err++;
    end
    check({name, "_env_errs"}, 32'(env_err), 32'd0);
    check({name, "_txd_errs"}, 32'(txd_err), 32'd0);
    check({name, "_done_in_busy"}, 32'(done_in_busy), 32'd0);
    runs.delete();
    for (int i = 0; i < obs_env.size(); i++) begin
      if (i == 0 || obs_env[i] != obs_env[i-1]) runs.push_back(1);
      else runs[runs.size()-1] = runs[runs.size()-1] + 1;
    end
    check({name, "_runs"}, 32'(runs.size()), rep ? 32'd3 : 32'd67);
    if (!rep && runs.size() >= 67) begin
      for (int b = 0; b < 32; b++) word[b] = (runs[3 + 2*b] > 2*UNIT);
      check({name, "_dec_addr"}, 32'(word[7:0]), 32'(a));
      check({name, "_dec_cmd"}, 32'(word[23:16]), 32'(c));
      check({name, "_dec_inv"}, 32'({word[31:24], word[15:8]}), 32'({~word[23:16], ~word[7:0]}));
    end
  endtask

  task automatic run_frame(input string name, input bit s, input bit r, input logic [7:0] a,
                           input logic [7:0] c, input int inject_at, input bit inject_done);
    request(s, r, a, c);
    capture(inject_at, ~a, inject_done);
    compare_frame(name, !s, a, c);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    bit s, r;
    logic [7:0] a, c;

    repeat (3) @(negedge CLOCK_50);
    check("reset_outputs", 32'({IRDA_TXD, ir_env, busy, tx_done}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // Reset in the middle of the leader mark.
    request(1'b1, 1'b0, 8'h12, 8'h34);
    repeat (50) @(negedge CLOCK_50);
    check("pre_reset_busy_env", 32'({busy, ir_env}), 32'h3);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", 32'({IRDA_TXD, ir_env, busy, tx_done}), 32'd0);
    repeat (3) @(negedge CLOCK_50);
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (tx_done !== 1'b0 || busy !== 1'b0) hits++;
    end
    check("no_done_after_reset", 32'(hits), 32'd0);

    // All-zero address/command.
    run_frame("zero", 1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    check("zero_busy_1210", 32'(busy_len), 32'd1210);
    if (runs.size() >= 4) begin
      check("zero_lead_mark", 32'(runs[0]), 32'd160);
      check("zero_lead_space", 32'(runs[1]), 32'd80);
      check("zero_bit0_mark", 32'(runs[2]), 32'd10);
      check("zero_bit0_space", 32'(runs[3]), 32'd10);
    end
    repeat (3) @(negedge CLOCK_50);

    // Known pattern decode.
    run_frame("a5_3c", 1'b1, 1'b0, 8'hA5, 8'h3C, 0, 1'b0);
    begin
      logic [31:0] w = 32'd0;
      if (runs.size() >= 67) for (int b = 0; b < 32; b++) w[b] = (runs[3 + 2*b] > 2*UNIT);
      check("a5_3c_word", w, 32'hC33C5AA5);
    end
    repeat (3) @(negedge CLOCK_50);

    // Repeat frame alone.
    run_frame("repeat", 1'b0, 1'b1, 8'h00, 8'h00, 0, 1'b0);
    check("repeat_busy_210", 32'(busy_len), 32'd210);
    repeat (3) @(negedge CLOCK_50);

    // Start and repeat together: start wins.
    run_frame("priority", 1'b1, 1'b1, 8'h5E, 8'h81, 0, 1'b0);
    repeat (3) @(negedge CLOCK_50);

    // Requests while busy and in the done cycle are ignored; next cycle is accepted.
    run_frame("reject", 1'b1, 1'b0, 8'h6B, 8'hD2, 500, 1'b1);
    run_frame("back2back", 1'b1, 1'b0, 8'h1F, 8'h40, 0, 1'b0);
    repeat (3) @(negedge CLOCK_50);

    // Randomized requests.
    for (int i = 0; i < 6; i++) begin
      s = 1'($urandom_range(0, 1));
      r = s ? 1'($urandom_range(0, 1)) : 1'b1;
      a = 8'($urandom);
      c = 8'($urandom);
      run_frame("rand", s, r, a, c, 0, 1'b0);
      repeat ($urandom_range(0, 4)) @(negedge CLOCK_50);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
